// File: rtl/led_fill_to_bin.sv
// Thermometer (fill) code to binary decoder for asynchronous board inputs.
// Synchronises, debounces, validates and publishes the count over valid/ready.
module led_fill_to_bin #(
   parameter int WIDTH    = 10,
   parameter int VAL_W    = 4,
   parameter int DEBOUNCE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] fill_in,
   output logic [VAL_W-1:0] out_value,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   input  logic             ovr_clr
);

   localparam int CNT_W = $clog2(DEBOUNCE) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       state_q, state_d;
   logic [VAL_W-1:0] value_q, value_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             set_ovr;

   // Value is the highest set bit position + 1; any zero below it marks a bubble.
   function automatic logic [VAL_W:0] decode(input logic [WIDTH-1:0] code);
      logic [VAL_W-1:0] v;
      logic             e;
      v = '0;
      e = 1'b0;
      for (int i = 0; i < WIDTH; i++)
         if (code[i]) v = VAL_W'(i + 1);
      for (int i = 0; i < WIDTH; i++)
         if ((VAL_W'(i) < v) && !code[i]) e = 1'b1;
      return {e, v};
   endfunction

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      value_d   = value_q;
      err_d     = err_q;
      valid_d   = valid_q;
      set_ovr   = 1'b0;

      case (state_q)
         IDLE: begin
            if (sync2_q != last_q) begin
               cand_d  = sync2_q;
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (sync2_q == last_q) begin
               state_d = IDLE;
            end else if (sync2_q != cand_q) begin
               cand_d = sync2_q;
               cnt_d  = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = COMMIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         COMMIT: begin
            last_d           = cand_q;
            {err_d, value_d} = decode(cand_q);
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A new commit always wins over the consumer draining the old value.
      if (state_q == COMMIT) begin
         valid_d = 1'b1;
         set_ovr = valid_q && !out_ready;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      overrun_d = set_ovr ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cand_q    <= '0;
         last_q    <= '0;
         cnt_q     <= '0;
         state_q   <= IDLE;
         value_q   <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sync1_q   <= fill_in;
         sync2_q   <= sync1_q;
         cand_q    <= cand_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         value_q   <= value_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_value = value_q;
   assign out_err   = err_q;
   assign out_valid = valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_led_fill_to_bin.sv
// Directed self-checking bench for led_fill_to_bin (WIDTH=10, VAL_W=4, DEBOUNCE=16).
module tb_led_fill_to_bin;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] fill_in;
   logic [3:0] out_value;
   logic       out_err;
   logic       out_valid;
   logic       out_ready;
   logic       overrun;
   logic       ovr_clr;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         lat;
   int         pulses;
   logic [3:0] seen_v;

   led_fill_to_bin #(.WIDTH(10), .VAL_W(4), .DEBOUNCE(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fill_in   (fill_in),
      .out_value (out_value),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges until out_valid rises, bounded so a dead DUT cannot hang the run.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!out_valid && cycles < 200);
   endtask

   task automatic run_count(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            pulses++;
            seen_v = out_value;
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      fill_in   = '0;
      out_ready = 1'b1;
      ovr_clr   = 1'b0;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_value", out_value, 0);
      check("rst_err", out_err, 0);
      check("rst_ovr", overrun, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle input equal to the reset code never publishes.
      pulses = 0;
      run_count(40);
      check("idle_pulses", pulses, 0);
      check("idle_value", out_value, 0);

      // Clean fills and exact latency.
      fill_in = 10'b0001111111;
      wait_valid(lat);
      check("lat_7", lat, 20);
      check("val_7", out_value, 7);
      check("err_7", out_err, 0);
      tick(1);
      check("drain_7", out_valid, 0);
      fill_in = 10'b1111111111;
      wait_valid(lat);
      check("lat_10", lat, 20);
      check("val_10", out_value, 10);
      check("err_10", out_err, 0);

      // Bouncing bit3 never settles, then one publish of the held code.
      pulses = 0;
      seen_v = '0;
      fill_in = 10'b0000001111;
      for (int i = 0; i < 12; i++) begin
         run_count(5);
         fill_in = fill_in ^ 10'b0000001000;
      end
      fill_in = 10'b0000001111;
      run_count(40);
      check("bounce_pulses", pulses, 1);
      check("bounce_val", seen_v, 4);

      // Short glitch that returns to the last published code.
      pulses = 0;
      fill_in = 10'b0000011111;
      run_count(3);
      fill_in = 10'b0000001111;
      run_count(40);
      check("glitch_pulses", pulses, 0);

      // Bubbled codes.
      fill_in = 10'b0000010111;
      wait_valid(lat);
      check("bub_val", out_value, 5);
      check("bub_err", out_err, 1);
      tick(1);
      fill_in = 10'b0000000011;
      wait_valid(lat);
      check("clean2_val", out_value, 2);
      check("clean2_err", out_err, 0);
      tick(1);
      fill_in = 10'b1000000000;
      wait_valid(lat);
      check("top_val", out_value, 10);
      check("top_err", out_err, 1);
      tick(1);

      // Overwrite of an unaccepted value.
      out_ready = 1'b0;
      fill_in = 10'b0000000111;
      wait_valid(lat);
      check("hold_val3", out_value, 3);
      check("hold_ovr0", overrun, 0);
      fill_in = 10'b0000111111;
      tick(19);
      check("pre_ovw_val", out_value, 3);
      check("pre_ovw_ovr", overrun, 0);
      tick(1);
      check("ovw_val", out_value, 6);
      check("ovw_ovr", overrun, 1);
      check("ovw_valid", out_valid, 1);
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      check("clr_ovr", overrun, 0);
      check("clr_valid", out_valid, 1);

      // Commit coincident with a transfer is not an overrun.
      fill_in = 10'b0000000001;
      tick(19);
      out_ready = 1'b1;
      tick(1);
      check("coin_val", out_value, 1);
      check("coin_valid", out_valid, 1);
      check("coin_ovr", overrun, 0);
      tick(1);
      check("coin_drain", out_valid, 0);
      out_ready = 1'b0;

      // Overrun set wins over a same-cycle clear.
      fill_in = 10'b0000000011;
      wait_valid(lat);
      check("pre_set_val", out_value, 2);
      fill_in = 10'b0000001111;
      tick(19);
      ovr_clr = 1'b1;
      tick(1);
      ovr_clr = 1'b0;
      check("setwin_ovr", overrun, 1);
      check("setwin_val", out_value, 4);

      // Async reset mid-settle with out_valid and overrun high.
      fill_in = 10'b0000011111;
      tick(6);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_value", out_value, 0);
      check("arst_err", out_err, 0);
      check("arst_ovr", overrun, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_valid(lat);
      check("rep_lat", lat, 20);
      check("rep_val", out_value, 5);
      check("rep_err", out_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
